// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and constants for the 4:1 round-robin output arbiter.
package mux4_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int         BURST_W       = 8;
  // Pointer value after reset, chosen so requester 0 is first in circular order.
  localparam logic [1:0] RR_LAST_RESET = 2'd3;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/output bundle of the shared 4:1 mux arbiter.
interface mux4_rr_arbiter_if #(
  parameter int DATA_W = 1
);
  logic [3:0]        req;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic [DATA_W-1:0] data3;
  logic [3:0]        gnt;
  logic [1:0]        select;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;

  modport master (
    output req, data0, data1, data2, data3,
    input  gnt, select, out_data, out_valid
  );

  modport slave (
    input  req, data0, data1, data2, data3,
    output gnt, select, out_data, out_valid
  );
endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Circular priority pick: first set req at or after start, optionally skipping one index.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] start,
  input  logic       excl_en,
  input  logic [1:0] excl,
  output logic       found,
  output logic [1:0] idx
);

  always_comb begin
    logic [1:0] cand;
    cand  = start;
    found = 1'b0;
    idx   = start;
    for (int i = 0; i < 4; i++) begin
      cand = start + 2'(i);
      if (!found && req[cand] && !(excl_en && (cand == excl))) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 output mux with burst-capped grants.
//
//   state    | meaning
//   ST_IDLE  | no owner, gnt=0; picks the next requester after `last`
//   ST_GRANT | owner=select; captures beats while req[owner] holds, releases on drop or cap
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int DATA_W    = 1,
  parameter int MAX_BURST = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mux4_rr_arbiter_if.slave   bus
);

  localparam logic [BURST_W-1:0] BURST_CAP = BURST_W'(MAX_BURST);
  localparam logic [BURST_W-1:0] SAT_LIM   = (MAX_BURST == 0) ? '1 : BURST_CAP;

  arb_state_e          state_q, state_d;
  logic [3:0]          gnt_q, gnt_d;
  logic [1:0]          sel_q, sel_d;
  logic [1:0]          last_q, last_d;
  logic [BURST_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_valid_q;

  logic                capture;
  logic                owner_req;
  logic                cap_hit;
  logic                pick_found;
  logic [1:0]          pick_idx;
  logic [1:0]          pick_start;
  logic                pick_excl_en;

  // Idle searches after the last owner; release searches after the owner, excluding it.
  assign pick_excl_en = (state_q == ST_GRANT);
  assign pick_start   = pick_excl_en ? (sel_q + 2'd1) : (last_q + 2'd1);

  rr_pick4 u_pick (
    .req     (bus.req),
    .start   (pick_start),
    .excl_en (pick_excl_en),
    .excl    (sel_q),
    .found   (pick_found),
    .idx     (pick_idx)
  );

  assign owner_req = bus.req[sel_q];
  assign cap_hit   = (MAX_BURST != 0) && (cnt_q == BURST_CAP) && pick_found;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_GRANT;
          gnt_d   = onehot4(pick_idx);
          sel_d   = pick_idx;
          cnt_d   = BURST_W'(1);
        end
      end
      ST_GRANT: begin
        capture = owner_req;
        if (owner_req && (cnt_q < SAT_LIM)) cnt_d = cnt_q + BURST_W'(1);
        if (!owner_req || cap_hit) begin
          last_d = sel_q;
          if (pick_found) begin
            gnt_d = onehot4(pick_idx);
            sel_d = pick_idx;
            cnt_d = BURST_W'(1);
          end else begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      last_q  <= RR_LAST_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= capture;
      if (capture) begin
        case (sel_q)
          2'd0:    out_data_q <= bus.data0;
          2'd1:    out_data_q <= bus.data1;
          2'd2:    out_data_q <= bus.data2;
          default: out_data_q <= bus.data3;
        endcase
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.select    = sel_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench: directed vector table, corner sequences and random traffic vs a model.
module tb_mux4_rr_arbiter;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]    req;
  logic [DW-1:0] d [4];

  mux4_rr_arbiter_if #(.DATA_W(DW)) bus_a ();
  mux4_rr_arbiter_if #(.DATA_W(DW)) bus_b ();

  assign bus_a.req = req;
  assign bus_a.data0 = d[0];
  assign bus_a.data1 = d[1];
  assign bus_a.data2 = d[2];
  assign bus_a.data3 = d[3];
  assign bus_b.req = req;
  assign bus_b.data0 = d[0];
  assign bus_b.data1 = d[1];
  assign bus_b.data2 = d[2];
  assign bus_b.data3 = d[3];

  mux4_rr_arbiter #(.DATA_W(DW), .MAX_BURST(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  mux4_rr_arbiter #(.DATA_W(DW), .MAX_BURST(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  logic [3:0]    act_gnt   [2];
  logic [1:0]    act_sel   [2];
  logic          act_valid [2];
  logic [DW-1:0] act_data  [2];
  assign act_gnt[0] = bus_a.gnt;       assign act_gnt[1] = bus_b.gnt;
  assign act_sel[0] = bus_a.select;    assign act_sel[1] = bus_b.select;
  assign act_valid[0] = bus_a.out_valid; assign act_valid[1] = bus_b.out_valid;
  assign act_data[0] = bus_a.out_data; assign act_data[1] = bus_b.out_data;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: owner index (-1 = nobody), burst length so far, rr pointer.
  int            m_owner [2];
  int            m_last  [2];
  int            m_cnt   [2];
  int            m_sel   [2];
  logic          m_valid [2];
  logic [DW-1:0] m_data  [2];
  int            maxb    [2];

  typedef struct {
    logic [3:0]    req;
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic          valid;
    logic [DW-1:0] data;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rr_next(input int from, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset(input int k);
    m_owner[k] = -1;
    m_last[k]  = 3;
    m_cnt[k]   = 0;
    m_sel[k]   = 0;
    m_valid[k] = 1'b0;
    m_data[k]  = '0;
  endtask

  task automatic model_step(input int k);
    int o;
    logic [3:0] others;
    bit rel;
    if (m_owner[k] < 0) begin
      m_valid[k] = 1'b0;
      o = rr_next(m_last[k], req);
      if (o >= 0) begin
        m_owner[k] = o;
        m_sel[k]   = o;
        m_cnt[k]   = 1;
      end
    end else begin
      o = m_owner[k];
      others = req & ~(4'b0001 << o);
      rel = !req[o] || (maxb[k] != 0 && m_cnt[k] == maxb[k] && others != 0);
      m_valid[k] = req[o];
      if (req[o]) begin
        m_data[k] = d[o];
        m_cnt[k]  = (m_cnt[k] + 1 > ((maxb[k] != 0) ? maxb[k] : 255)) ? m_cnt[k] : m_cnt[k] + 1;
      end
      if (rel) begin
        m_last[k] = o;
        if (others != 0) begin
          m_owner[k] = rr_next(o, others);
          m_sel[k]   = m_owner[k];
          m_cnt[k]   = 1;
        end else begin
          m_owner[k] = -1;
        end
      end
    end
  endtask

  task automatic check_dut(input int k);
    logic [3:0] eg;
    int gi;
    eg = (m_owner[k] < 0) ? 4'b0000 : 4'(4'b0001 << m_owner[k]);
    chk($sformatf("gnt[%0d]", k), 32'(act_gnt[k]), 32'(eg));
    chk($sformatf("select[%0d]", k), 32'(act_sel[k]), 32'(m_sel[k]));
    chk($sformatf("out_valid[%0d]", k), 32'(act_valid[k]), 32'(m_valid[k]));
    chk($sformatf("out_data[%0d]", k), 32'(act_data[k]), 32'(m_data[k]));
    chk($sformatf("gnt_onehot0[%0d]", k), 32'($onehot0(act_gnt[k])), 32'd1);
    if (act_gnt[k] != 4'b0000) begin
      gi = 0;
      for (int i = 0; i < 4; i++) if (act_gnt[k][i]) gi = i;
      chk($sformatf("select_eq_gnt[%0d]", k), 32'(act_sel[k]), 32'(gi));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset(0);
    model_reset(1);
    #1;
    check_dut(0);
    check_dut(1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int beats [4];
  int gaps;
  int off_gnt;

  initial begin
    maxb[0] = 8;
    maxb[1] = 0;
    req = 4'b0000;
    for (int i = 0; i < 4; i++) d[i] = 8'(8'hA0 + i);

    tbl[0]  = '{4'b1010, 4'b0010, 2'd1, 1'b0, 8'h00};
    tbl[1]  = '{4'b1010, 4'b0010, 2'd1, 1'b1, 8'hA1};
    tbl[2]  = '{4'b0100, 4'b0100, 2'd2, 1'b0, 8'hA1};
    tbl[3]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 8'hA2};
    tbl[4]  = '{4'b0001, 4'b0001, 2'd0, 1'b0, 8'hA2};
    tbl[5]  = '{4'b0001, 4'b0001, 2'd0, 1'b1, 8'hA0};
    tbl[6]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 8'hA0};
    tbl[7]  = '{4'b1000, 4'b1000, 2'd3, 1'b0, 8'hA0};
    tbl[8]  = '{4'b1001, 4'b1000, 2'd3, 1'b1, 8'hA3};
    tbl[9]  = '{4'b0001, 4'b0001, 2'd0, 1'b0, 8'hA3};
    tbl[10] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 8'hA3};

    #1;
    do_reset();

    // Directed table: first grant, owner drop with hand-over, idle and re-grant.
    for (int i = 0; i < 11; i++) begin
      req = tbl[i].req;
      step();
      chk($sformatf("tbl%0d_gnt", i), 32'(bus_a.gnt), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_sel", i), 32'(bus_a.select), 32'(tbl[i].sel));
      chk($sformatf("tbl%0d_valid", i), 32'(bus_a.out_valid), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d_data", i), 32'(bus_a.out_data), 32'(tbl[i].data));
    end

    // All four requesting: 8-beat bursts rotate 0,1,2,3 with no gap.
    do_reset();
    for (int i = 0; i < 4; i++) d[i] = 8'(i);
    req = 4'b1111;
    step();
    for (int i = 0; i < 4; i++) beats[i] = 0;
    gaps = 0;
    for (int e = 2; e <= 33; e++) begin
      step();
      if (bus_a.out_valid) beats[bus_a.out_data[1:0]]++;
      else gaps++;
    end
    for (int i = 0; i < 4; i++) chk($sformatf("burst_beats_%0d", i), 32'(beats[i]), 32'd8);
    chk("burst_gaps", 32'(gaps), 32'd0);
    chk("burst_wrap_gnt", 32'(bus_a.gnt), 32'b0001);

    // Single requester past the cap keeps the grant.
    do_reset();
    req = 4'b1000;
    beats[0] = 0;
    off_gnt = 0;
    for (int e = 1; e <= 21; e++) begin
      step();
      if (bus_a.out_valid) beats[0]++;
      if (bus_a.gnt != 4'b1000) off_gnt++;
    end
    chk("single_beats", 32'(beats[0]), 32'd20);
    chk("single_gnt_changes", 32'(off_gnt), 32'd0);

    // Asynchronous reset in the middle of a burst.
    do_reset();
    req = 4'b1111;
    repeat (5) step();
    #3;
    rst_n = 1'b0;
    model_reset(0);
    model_reset(1);
    #1;
    chk("midrst_gnt", 32'(bus_a.gnt), 32'd0);
    chk("midrst_valid", 32'(bus_a.out_valid), 32'd0);
    check_dut(0);
    check_dut(1);
    req = 4'b1100;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("postrst_gnt", 32'(bus_a.gnt), 32'b0100);
    chk("postrst_sel", 32'(bus_a.select), 32'd2);

    // Unlimited burst: owner 0 never released while holding its request.
    do_reset();
    req = 4'b0011;
    beats[0] = 0;
    off_gnt = 0;
    for (int e = 1; e <= 50; e++) begin
      step();
      if (bus_b.out_valid) beats[0]++;
      if (bus_b.gnt != 4'b0001) off_gnt++;
    end
    chk("unlimited_beats", 32'(beats[0]), 32'd49);
    chk("unlimited_gnt_changes", 32'(off_gnt), 32'd0);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom_range(0, 255));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
